// File: rtl/gate_deadtime.sv
// gate_deadtime: complementary gate-drive conditioning for the two legs of an
// H-bridge. Each leg runs an independent FSM that inserts dead time on every
// entry into conduction, enforces a minimum on-time on commutation, and drops
// both gates on fault or loss of enable. Gate, dead-time and hold outputs are
// registered decodes of the next state, so they change one edge after sampling.
module gate_deadtime #(
   parameter int DEAD_CYC   = 80,
   parameter int MIN_ON_CYC = 200,
   parameter int CNT_W      = 12
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       enable,
   input  logic       fault,
   input  logic       leg_cmd_l,
   input  logic       leg_cmd_r,
   output logic       LUDIN,
   output logic       LDDIN,
   output logic       RUDIN,
   output logic       RDDIN,
   output logic [1:0] dt_active,
   output logic [1:0] min_on_hold
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DT_UP = 3'd1,
      ST_DT_DN = 3'd2,
      ST_UP    = 3'd3,
      ST_DN    = 3'd4
   } leg_state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DT_LAST  = CNT_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON_CYC - 1);

   logic       kill_s;
   logic [1:0] cmd_s;
   logic [1:0] upper_s;
   logic [1:0] lower_s;
   logic [1:0] dt_s;
   logic [1:0] hold_s;

   // fault or missing run permission blocks both legs unconditionally
   assign kill_s = fault | ~enable;
   // index 0 is the left leg, index 1 the right leg
   assign cmd_s  = {leg_cmd_r, leg_cmd_l};

   for (genvar g = 0; g < 2; g++) begin : g_leg
      leg_state_t       state_r;
      leg_state_t       state_nxt_s;
      logic [CNT_W-1:0] dt_cnt_r;
      logic [CNT_W-1:0] dt_cnt_nxt_s;
      logic [CNT_W-1:0] on_cnt_r;
      logic [CNT_W-1:0] on_cnt_nxt_s;
      logic             hold_nxt_s;
      logic             on_sat_s;
      logic             opp_s;
      logic             upper_r;
      logic             lower_r;
      logic             dt_r;
      logic             hold_r;

      // min-on satisfied once the saturating on-time counter reaches its limit
      assign on_sat_s = (on_cnt_r == ON_LAST);
      // request points at the switch that is currently off (only meaningful in UP/DN)
      assign opp_s    = (state_r == ST_UP) ? ~cmd_s[g] : cmd_s[g];

      // next state, counters and min-on hold for this leg
      always_comb begin
         state_nxt_s  = state_r;
         dt_cnt_nxt_s = CNT_ZERO;
         on_cnt_nxt_s = CNT_ZERO;
         hold_nxt_s   = 1'b0;
         if (kill_s) begin
            state_nxt_s = ST_IDLE;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_nxt_s = cmd_s[g] ? ST_DT_UP : ST_DT_DN;
               end
               ST_DT_UP, ST_DT_DN: begin
                  // both gates are already off, so a retarget keeps the running count
                  if (dt_cnt_r == DT_LAST) begin
                     state_nxt_s = (state_r == ST_DT_UP) ? ST_UP : ST_DN;
                  end else begin
                     state_nxt_s  = cmd_s[g] ? ST_DT_UP : ST_DT_DN;
                     dt_cnt_nxt_s = dt_cnt_r + CNT_ONE;
                  end
               end
               ST_UP, ST_DN: begin
                  on_cnt_nxt_s = on_sat_s ? on_cnt_r : (on_cnt_r + CNT_ONE);
                  if (opp_s && on_sat_s) begin
                     state_nxt_s  = (state_r == ST_UP) ? ST_DT_DN : ST_DT_UP;
                     on_cnt_nxt_s = CNT_ZERO;
                  end else if (opp_s) begin
                     hold_nxt_s = 1'b1;
                  end else begin
                     hold_nxt_s = 1'b0;
                  end
               end
               default: begin
                  state_nxt_s = ST_IDLE;
               end
            endcase
         end
      end

      // leg state, counters and registered output decodes
      always_ff @(posedge clk) begin
         if (Reset) begin
            state_r  <= ST_IDLE;
            dt_cnt_r <= CNT_ZERO;
            on_cnt_r <= CNT_ZERO;
            upper_r  <= 1'b0;
            lower_r  <= 1'b0;
            dt_r     <= 1'b0;
            hold_r   <= 1'b0;
         end else begin
            state_r  <= state_nxt_s;
            dt_cnt_r <= dt_cnt_nxt_s;
            on_cnt_r <= on_cnt_nxt_s;
            upper_r  <= (state_nxt_s == ST_UP);
            lower_r  <= (state_nxt_s == ST_DN);
            dt_r     <= (state_nxt_s == ST_DT_UP) || (state_nxt_s == ST_DT_DN);
            hold_r   <= hold_nxt_s;
         end
      end

      assign upper_s[g] = upper_r;
      assign lower_s[g] = lower_r;
      assign dt_s[g]    = dt_r;
      assign hold_s[g]  = hold_r;
   end

   assign LUDIN       = upper_s[0];
   assign LDDIN       = lower_s[0];
   assign RUDIN       = upper_s[1];
   assign RDDIN       = lower_s[1];
   assign dt_active   = dt_s;
   assign min_on_hold = hold_s;

endmodule

// File: doc/gate_deadtime.md
# gate_deadtime

Gate-drive conditioning stage between the leg-command logic and the four IGBT driver pins (LUDIN, LDDIN, RUDIN, RDDIN) of the H-bridge power unit. It takes one requested leg state per half-bridge and produces complementary gate signals. Each leg gets guaranteed dead time, minimum on-time and immediate fault blanking. Upper and lower switches of a leg are never driven high together, in any cycle, under any input sequence.

## Interface
Parameters:
- DEAD_CYC, 80, dead-time length in clk cycles (2 µs at 40 MHz); legal 1..4095
- MIN_ON_CYC, 200, minimum conduction time in clk cycles (5 µs); legal 1..4095
- CNT_W, 12, width of the per-leg dead-time and on-time counters

Ports:
- clk, in, 1, system clock (40 MHz)
- Reset, in, 1, reset: one clock; reset is synchronous and active-high
- enable, in, 1, run permission (start_stop & ~err_all); low forces all gates off
- fault, in, 1, hard block; overrides everything, all gates off
- leg_cmd_l, in, 1, left leg request: 1 = upper on, 0 = lower on
- leg_cmd_r, in, 1, right leg request, same encoding
- LUDIN, out, 1, left upper gate
- LDDIN, out, 1, left lower gate
- RUDIN, out, 1, right upper gate
- RDDIN, out, 1, right lower gate
- dt_active, out, 2, [1]=right, [0]=left; high while that leg is in a dead-time state
- min_on_hold, out, 2, high while a leg's request differs from its conducting state and is blocked by min-on

## Operation
- Two identical, independent leg FSMs. States: IDLE, DT_UP, DT_DN, UP, DN.
- Gate outputs are registered decodes of the state: upper = (state==UP), lower = (state==DN). Both are low in IDLE, DT_UP and DT_DN.
- kill = fault | ~enable. It has the highest priority in every state: next state is IDLE, and counters clear to 0.
- IDLE: if ~kill, go to DT_UP when cmd=1, or to DT_DN when cmd=0. dt_cnt clears to 0.
- DT_x: dt_cnt increments each cycle. When dt_cnt == DEAD_CYC-1, go to UP (from DT_UP) or DN (from DT_DN) and clear on_cnt.
- In DT_x, if cmd flips, retarget to the other DT state and keep dt_cnt counting. Dead time is not restarted, because both gates are already off.
- UP/DN: on_cnt increments and saturates at MIN_ON_CYC-1. If cmd requests the opposite side and on_cnt == MIN_ON_CYC-1, go to the opposite DT state and clear dt_cnt. If the request comes earlier, stay in the state and assert min_on_hold.
- kill in UP/DN ignores min-on. Every re-entry to conduction passes through a DT state, so dead time after a fault or disable is guaranteed.
- Counters are unsigned CNT_W bits and never wrap. dt_cnt is bounded by the exit condition; on_cnt saturates.
- Inputs are synchronous to clk and are sampled every cycle. No filtering is done; upstream logic provides clean commands.

## Timing
- Reset: both FSMs go to IDLE. All four gates, dt_active and min_on_hold are 0 on the cycle after Reset is sampled high, and stay 0 while Reset is high.
- Reset asserted mid-conduction: gates go low on the next edge, the same as kill.
- kill sampled high at edge t: gates are low after edge t (1-cycle latency).
- Startup: kill deasserted and sampled at edge t gives IDLE→DT at t. The first gate goes high at edge t+DEAD_CYC.
- Commutation: opposite cmd sampled at edge t with min-on satisfied.
  - Active gate goes low at t.
  - Other gate goes high at t+DEAD_CYC.
  - Exactly DEAD_CYC cycles have both gates low.
- Commutation blocked by min-on: the transition occurs at the first edge where on_cnt == MIN_ON_CYC-1 and the request still holds. A gate therefore stays high for at least MIN_ON_CYC cycles.
- Request withdrawn during the min-on hold: stay in the current state with no gap, and min_on_hold drops.
- fault and a cmd change on the same edge: fault wins, and the leg goes to IDLE.

## Test plan
Bench uses DEAD_CYC=4, MIN_ON_CYC=6.
- Reset high for 3 cycles with enable=1, cmd_l=1 → all gates 0 throughout. Release at edge t → LUDIN rises at t+4 (after the DT_UP sequence); LDDIN stays 0.
- Left leg in UP for 10 cycles, cmd_l toggled to 0 → LUDIN falls next edge, 4 cycles with both low, then LDDIN=1. dt_active[0] is high for exactly those 4 cycles.
- cmd_r toggled 2 cycles after RUDIN rises → min_on_hold[1]=1 for 4 cycles. RUDIN high time is exactly 6 cycles, then 4 dead cycles, then RDDIN rises.
- fault pulse of 1 cycle during DN → LDDIN low the next cycle. Re-entry passes through 4 dead cycles; min-on is ignored.
- cmd flipped during DT (cycle 2 of 4) → opposite gate turns on 2 cycles later, with no dead-time restart.
- Random cmd_l, cmd_r, fault and enable for 10^5 cycles → assertions hold:
  - upper&lower is never 1 on either leg;
  - every off→on transition is preceded by ≥4 both-low cycles;
  - every on pulse not ended by kill lasts ≥6 cycles.
